// File: rtl/rob_retire.sv
// rob_retire
// Reorder buffer and in-order retire unit. It sits at the consumer end of the
// rename/decode stage.
//   - It hands out the next WIDTH free ROB indices to the decoder (rob_entries).
//   - For each allocated op it stores the two old physical aliases and the two
//     architectural destination registers.
//   - Completion ports mark entries done.
//   - Up to RETIRE_W entries retire per cycle, strictly oldest-first. Their old
//     aliases are returned on free_regs, with 0 in unused slots.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rob_entries        lane i = (tail + i) mod ENTRIES
//   alloc_valid/ready  per-lane allocate request (contiguous from lane 0) / room for WIDTH ops
//   alloc_old/arch     per-lane old aliases (2 x PR_ADDR_W) and arch dests (2 x 4 bits)
//   cmplt_valid/rob    completion strobes and the ROB index completed on each port
//   flush              discard every entry
//   retire_valid       registered per-slot retire strobe
//   free_regs          registered freed aliases per slot
//   retire_arch        registered arch dests per slot
//   count, empty       occupancy
module rob_retire #(
  parameter int WIDTH     = 4,
  parameter int ENTRIES   = 32,
  parameter int IDX_W     = 5,
  parameter int PR_ADDR_W = 5,
  parameter int CMPLT_W   = 6,
  parameter int RETIRE_W  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [WIDTH*IDX_W-1:0]          rob_entries,
  input  logic [WIDTH-1:0]                alloc_valid,
  output logic                            alloc_ready,
  input  logic [WIDTH*2*PR_ADDR_W-1:0]    alloc_old,
  input  logic [WIDTH*8-1:0]              alloc_arch,
  input  logic [CMPLT_W-1:0]              cmplt_valid,
  input  logic [CMPLT_W*IDX_W-1:0]        cmplt_rob,
  input  logic                            flush,
  output logic [RETIRE_W-1:0]             retire_valid,
  output logic [RETIRE_W*2*PR_ADDR_W-1:0] free_regs,
  output logic [RETIRE_W*8-1:0]           retire_arch,
  output logic [IDX_W:0]                  count,
  output logic                            empty
);

  localparam int PTR_W = IDX_W + 1;
  localparam int OLD_W = 2 * PR_ADDR_W;
  localparam logic [PTR_W-1:0] READY_MAX = PTR_W'(ENTRIES - WIDTH);

  // Pointers carry an extra wrap bit so that full and empty can be told apart.
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] done;
  logic [ENTRIES-1:0] valid_next;
  logic [ENTRIES-1:0] done_next;
  logic [OLD_W-1:0]   old_mem [ENTRIES];
  logic [7:0]         arch_mem [ENTRIES];
  logic [IDX_W-1:0]   lane_idx [WIDTH];
  logic [IDX_W-1:0]   slot_idx [RETIRE_W];
  logic [RETIRE_W-1:0] retire_mask;
  logic [PTR_W-1:0]   retire_n;
  logic [PTR_W-1:0]   alloc_n;
  logic               scan_stop;
  logic               alloc_fire;

  assign count       = tail - head;
  assign empty       = (count == '0);
  assign alloc_ready = (count <= READY_MAX);
  assign alloc_fire  = alloc_ready && !flush;

  // Index arithmetic is done on the low IDX_W bits, so it wraps naturally at ENTRIES.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign lane_idx[i] = tail[IDX_W-1:0] + IDX_W'(i);
    assign rob_entries[i*IDX_W +: IDX_W] = lane_idx[i];
  end

  for (genvar k = 0; k < RETIRE_W; k++) begin : g_slot
    assign slot_idx[k] = head[IDX_W-1:0] + IDX_W'(k);
  end

  // Lanes are contiguous from lane 0, so the popcount equals the number of lanes used.
  always_comb begin
    alloc_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (alloc_valid[i]) alloc_n = alloc_n + PTR_W'(1);
    end
  end

  // The retire scan looks only at registered done bits. A completion arriving
  // this cycle therefore cannot retire until the next cycle. The scan stops at
  // the first entry that is not both valid and done.
  always_comb begin
    retire_mask = '0;
    retire_n    = '0;
    scan_stop   = 1'b0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (!scan_stop && valid[slot_idx[k]] && done[slot_idx[k]]) begin
        retire_mask[k] = 1'b1;
        retire_n       = retire_n + PTR_W'(1);
      end else begin
        scan_stop = 1'b1;
      end
    end
  end

  // Next valid/done state is built in three steps:
  //   1. Completions are gated by the current valid bit.
  //   2. Retired entries are cleared.
  //   3. Newly allocated entries start not-done.
  // Allocation lanes never overlap retiring entries, because alloc_ready
  // guarantees free space beyond tail.
  always_comb begin
    valid_next = valid;
    done_next  = done;
    for (int c = 0; c < CMPLT_W; c++) begin
      if (cmplt_valid[c] && valid[cmplt_rob[c*IDX_W +: IDX_W]])
        done_next[cmplt_rob[c*IDX_W +: IDX_W]] = 1'b1;
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      if (retire_mask[k]) begin
        valid_next[slot_idx[k]] = 1'b0;
        done_next[slot_idx[k]]  = 1'b0;
      end
    end
    if (alloc_ready) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (alloc_valid[i]) begin
          valid_next[lane_idx[i]] = 1'b1;
          done_next[lane_idx[i]]  = 1'b0;
        end
      end
    end
  end

  // Control state and the registered retire outputs. Reset wins over flush.
  // Flush also suppresses both the retire and the alloc decided this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      valid        <= '0;
      done         <= '0;
      retire_valid <= '0;
      free_regs    <= '0;
      retire_arch  <= '0;
    end else if (flush) begin
      head         <= tail;
      valid        <= '0;
      done         <= '0;
      retire_valid <= '0;
      free_regs    <= '0;
      retire_arch  <= '0;
    end else begin
      valid <= valid_next;
      done  <= done_next;
      head  <= head + retire_n;
      if (alloc_ready) tail <= tail + alloc_n;
      for (int k = 0; k < RETIRE_W; k++) begin
        retire_valid[k]             <= retire_mask[k];
        free_regs[k*OLD_W +: OLD_W] <= retire_mask[k] ? old_mem[slot_idx[k]] : '0;
        retire_arch[k*8 +: 8]       <= retire_mask[k] ? arch_mem[slot_idx[k]] : '0;
      end
    end
  end

  // The payload store needs no reset, because an entry's fields are only read
  // while that entry is valid.
  always_ff @(posedge clk) begin
    if (!rst && alloc_fire) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (alloc_valid[i]) begin
          old_mem[lane_idx[i]]  <= alloc_old[i*OLD_W +: OLD_W];
          arch_mem[lane_idx[i]] <= alloc_arch[i*8 +: 8];
        end
      end
    end
  end

endmodule
